// File: rtl/serial_mmio_port.sv
// serial_mmio_port: CPU-facing serial peripheral.
// Bus writes to DATA queue bytes in a TX FIFO. A small FSM hands them to the
// UART transmitter over a send/ready handshake. A second FSM accepts bytes from
// the UART receiver over a ready/ack handshake into an RX FIFO, which the CPU
// drains by reading DATA. STATUS shows FIFO levels, idle state and a sticky
// overrun flag.
module serial_mmio_port #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic        clk,
   input  logic        sync_rstn,
   input  logic        bus_addr,
   input  logic        bus_wr,
   input  logic        bus_rd,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic [7:0]  serial_tx_data,
   output logic        serial_tx_send,
   input  logic        serial_tx_ready,
   input  logic [7:0]  serial_rx_data,
   input  logic        serial_rx_ready,
   output logic        serial_rx_ack
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] ZERO_CNT = (AW+1)'(0);

   typedef enum logic [1:0] {
      TX_IDLE      = 2'd0,
      TX_SEND      = 2'd1,
      TX_WAIT_BUSY = 2'd2,
      TX_WAIT_DONE = 2'd3
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE     = 2'd0,
      RX_ACK      = 2'd1,
      RX_WAIT_LOW = 2'd2
   } rx_state_e;

   // FIFO storage and bookkeeping
   logic [7:0]    tx_mem_q [DEPTH];
   logic [AW-1:0] tx_wptr_q, tx_rptr_q;
   logic [AW:0]   tx_cnt_q, tx_cnt_d;
   logic [7:0]    rx_mem_q [DEPTH];
   logic [AW-1:0] rx_wptr_q, rx_rptr_q;
   logic [AW:0]   rx_cnt_q, rx_cnt_d;

   // FSM state and registered outputs
   tx_state_e     tx_state_q;
   logic [7:0]    tx_data_q;
   logic          tx_send_q;
   rx_state_e     rx_state_q;
   logic          rx_ack_q;
   logic          ovr_q, ovr_d;
   logic [31:0]   rdata_q, rdata_d;

   // Per-cycle control decisions
   logic          tx_empty_s, tx_full_s, tx_pop_s, tx_push_s, tx_idle_s;
   logic          rx_empty_s, rx_full_s, rx_pop_s, rx_push_s, rx_space_s;
   logic          ovr_set_s, ovr_clr_s;
   logic [31:0]   status_s;
   logic          unused_wdata_s;

   assign unused_wdata_s = ^{bus_wdata[31:8], bus_wdata[7:4], bus_wdata[2:0]};

   // FIFO push/pop qualification, overrun detection and next counts
   always_comb begin
      tx_empty_s = (tx_cnt_q == ZERO_CNT);
      tx_full_s  = (tx_cnt_q == FULL_CNT);
      tx_idle_s  = tx_empty_s && (tx_state_q == TX_IDLE);
      // The transmitter FSM is the only consumer of the TX FIFO
      tx_pop_s   = (tx_state_q == TX_IDLE) && !tx_empty_s && serial_tx_ready;
      // A full FIFO still accepts a byte when the head leaves in the same cycle
      tx_push_s  = bus_wr && !bus_addr && (!tx_full_s || tx_pop_s);

      rx_empty_s = (rx_cnt_q == ZERO_CNT);
      rx_full_s  = (rx_cnt_q == FULL_CNT);
      rx_pop_s   = bus_rd && !bus_addr && !rx_empty_s;
      rx_space_s = !rx_full_s || rx_pop_s;
      rx_push_s  = (rx_state_q == RX_IDLE) && serial_rx_ready && rx_space_s;
      ovr_set_s  = (rx_state_q == RX_IDLE) && serial_rx_ready && !rx_space_s;
      ovr_clr_s  = bus_wr && bus_addr && bus_wdata[3];

      tx_cnt_d = tx_cnt_q + (AW+1)'(tx_push_s) - (AW+1)'(tx_pop_s);
      rx_cnt_d = rx_cnt_q + (AW+1)'(rx_push_s) - (AW+1)'(rx_pop_s);

      // Setting wins over clearing so a byte refused in the clear cycle is not lost silently
      if (ovr_set_s) begin
         ovr_d = 1'b1;
      end else if (ovr_clr_s) begin
         ovr_d = 1'b0;
      end else begin
         ovr_d = ovr_q;
      end
   end

   // STATUS register image and the bus read-data next value
   always_comb begin
      status_s               = 32'h0000_0000;
      status_s[0]            = !rx_empty_s;
      status_s[1]            = tx_full_s;
      status_s[2]            = tx_idle_s;
      status_s[3]            = ovr_q;
      status_s[8+AW:8]       = rx_cnt_q;
      status_s[16+AW:16]     = tx_cnt_q;

      rdata_d = rdata_q;
      if (bus_rd) begin
         if (bus_addr) begin
            rdata_d = status_s;
         end else if (rx_empty_s) begin
            rdata_d = 32'h0000_0000;
         end else begin
            rdata_d = {24'h00_0000, rx_mem_q[rx_rptr_q]};
         end
      end else begin
         rdata_d = rdata_q;
      end
   end

   // TX FIFO storage, pointers and count
   always_ff @(posedge clk or negedge sync_rstn) begin
      if (!sync_rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            tx_mem_q[i] <= 8'h00;
         end
         tx_wptr_q <= AW'(0);
         tx_rptr_q <= AW'(0);
         tx_cnt_q  <= ZERO_CNT;
      end else begin
         if (tx_push_s) begin
            tx_mem_q[tx_wptr_q] <= bus_wdata[7:0];
            tx_wptr_q           <= tx_wptr_q + AW'(1);
         end
         if (tx_pop_s) begin
            tx_rptr_q <= tx_rptr_q + AW'(1);
         end
         tx_cnt_q <= tx_cnt_d;
      end
   end

   // RX FIFO storage, pointers and count
   always_ff @(posedge clk or negedge sync_rstn) begin
      if (!sync_rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            rx_mem_q[i] <= 8'h00;
         end
         rx_wptr_q <= AW'(0);
         rx_rptr_q <= AW'(0);
         rx_cnt_q  <= ZERO_CNT;
      end else begin
         if (rx_push_s) begin
            rx_mem_q[rx_wptr_q] <= serial_rx_data;
            rx_wptr_q           <= rx_wptr_q + AW'(1);
         end
         if (rx_pop_s) begin
            rx_rptr_q <= rx_rptr_q + AW'(1);
         end
         rx_cnt_q <= rx_cnt_d;
      end
   end

   // Transmit handshake: pop a byte, pulse send, then follow ready low and back high
   always_ff @(posedge clk or negedge sync_rstn) begin
      if (!sync_rstn) begin
         tx_state_q <= TX_IDLE;
         tx_data_q  <= 8'h00;
         tx_send_q  <= 1'b0;
      end else begin
         tx_send_q <= 1'b0;
         case (tx_state_q)
            TX_IDLE: begin
               if (tx_pop_s) begin
                  tx_state_q <= TX_SEND;
                  tx_data_q  <= tx_mem_q[tx_rptr_q];
                  tx_send_q  <= 1'b1;
               end
            end
            TX_SEND: begin
               tx_state_q <= TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: begin
               if (!serial_tx_ready) begin
                  tx_state_q <= TX_WAIT_DONE;
               end
            end
            TX_WAIT_DONE: begin
               if (serial_tx_ready) begin
                  tx_state_q <= TX_IDLE;
               end
            end
            default: begin
               tx_state_q <= TX_IDLE;
            end
         endcase
      end
   end

   // Receive handshake: accept a byte when there is room, pulse ack, wait for ready to drop
   always_ff @(posedge clk or negedge sync_rstn) begin
      if (!sync_rstn) begin
         rx_state_q <= RX_IDLE;
         rx_ack_q   <= 1'b0;
      end else begin
         rx_ack_q <= 1'b0;
         case (rx_state_q)
            RX_IDLE: begin
               if (rx_push_s) begin
                  rx_state_q <= RX_ACK;
                  rx_ack_q   <= 1'b1;
               end
            end
            RX_ACK: begin
               rx_state_q <= RX_WAIT_LOW;
            end
            RX_WAIT_LOW: begin
               if (!serial_rx_ready) begin
                  rx_state_q <= RX_IDLE;
               end
            end
            default: begin
               rx_state_q <= RX_IDLE;
            end
         endcase
      end
   end

   // Bus read data and sticky overrun flag
   always_ff @(posedge clk or negedge sync_rstn) begin
      if (!sync_rstn) begin
         rdata_q <= 32'h0000_0000;
         ovr_q   <= 1'b0;
      end else begin
         rdata_q <= rdata_d;
         ovr_q   <= ovr_d;
      end
   end

   assign bus_rdata      = rdata_q;
   assign serial_tx_data = tx_data_q;
   assign serial_tx_send = tx_send_q;
   assign serial_rx_ack  = rx_ack_q;

endmodule

// File: tb/tb_serial_mmio_port.sv
// Directed bench for serial_mmio_port: a table of bus accesses with expected
// read data, plus hand-written handshake sequences for TX, RX, overrun and reset.
module tb_serial_mmio_port;

   logic        clk = 1'b0;
   logic        sync_rstn;
   logic        bus_addr_s;
   logic        bus_wr_s;
   logic        bus_rd_s;
   logic [31:0] bus_wdata_s;
   logic [31:0] bus_rdata_s;
   logic [7:0]  tx_data_s;
   logic        tx_send_s;
   logic        tx_ready_s;
   logic [7:0]  rx_data_s;
   logic        rx_ready_s;
   logic        rx_ack_s;

   int checks = 0;
   int errors = 0;

   // Transmitter model state (written only by the model process)
   logic        tx_hold = 1'b1;
   int          tx_timer = 0;
   logic [7:0]  sent_q[$];
   int          ack_cnt = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic        addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[16];

   serial_mmio_port #(.DEPTH(8), .AW(3)) dut (
      .clk             (clk),
      .sync_rstn       (sync_rstn),
      .bus_addr        (bus_addr_s),
      .bus_wr          (bus_wr_s),
      .bus_rd          (bus_rd_s),
      .bus_wdata       (bus_wdata_s),
      .bus_rdata       (bus_rdata_s),
      .serial_tx_data  (tx_data_s),
      .serial_tx_send  (tx_send_s),
      .serial_tx_ready (tx_ready_s),
      .serial_rx_data  (rx_data_s),
      .serial_rx_ready (rx_ready_s),
      .serial_rx_ack   (rx_ack_s)
   );

   always #5 clk = ~clk;

   // Transmitter model: log each send cycle, drop ready 2 cycles later, raise it 20 cycles after that; count acks
   always begin
      @(posedge clk);
      #1;
      if (tx_send_s) begin
         sent_q.push_back(tx_data_s);
         tx_timer = 1;
      end else if (tx_timer != 0) begin
         tx_timer = tx_timer + 1;
      end
      if (tx_timer == 22 || !sync_rstn) begin
         tx_timer = 0;
      end
      tx_ready_s = !tx_hold && !(tx_timer >= 2);
      if (rx_ack_s) begin
         ack_cnt = ack_cnt + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic bus_op(input logic rd, input logic wr, input logic addr, input logic [31:0] wd);
      bus_rd_s    = rd;
      bus_wr_s    = wr;
      bus_addr_s  = addr;
      bus_wdata_s = wd;
      tick();
      bus_rd_s    = 1'b0;
      bus_wr_s    = 1'b0;
   endtask

   task automatic wait_sends(input int n, input string name);
      int k;
      k = 0;
      while (sent_q.size() < n && k < 400) begin
         tick();
         k = k + 1;
      end
      check(name, 32'(sent_q.size()), 32'(n));
   endtask

   task automatic rx_byte(input logic [7:0] d, input string name);
      int k;
      rx_data_s  = d;
      rx_ready_s = 1'b1;
      k = 0;
      tick();
      while (!rx_ack_s && k < 10) begin
         tick();
         k = k + 1;
      end
      check(name, 32'(rx_ack_s), 32'd1);
      repeat (3) tick();
      rx_ready_s = 1'b0;
      tick();
   endtask

   initial begin
      int a0;
      int s0;
      sync_rstn   = 1'b0;
      bus_addr_s  = 1'b0;
      bus_wr_s    = 1'b0;
      bus_rd_s    = 1'b0;
      bus_wdata_s = 32'h0;
      rx_data_s   = 8'h00;
      rx_ready_s  = 1'b0;

      // Bus table: run with the transmitter held busy so the TX FIFO fills
      vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'h0,          32'h0000_0004};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,          32'h0000_0000};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h0,          32'h0000_0004};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000,  32'h0};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h0,          32'h0001_0000};
      for (int i = 5; i <= 12; i++) begin
         vecs[i] = '{1'b0, 1'b1, 1'b0, 32'(i - 4), 32'h0};
      end
      vecs[13] = '{1'b1, 1'b0, 1'b1, 32'h0,          32'h0008_0002};
      vecs[14] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFF7,  32'h0};
      vecs[15] = '{1'b1, 1'b0, 1'b1, 32'h0,          32'h0008_0002};

      repeat (3) tick();
      check("reset_rdata", bus_rdata_s, 32'h0);
      check("reset_tx_send", 32'(tx_send_s), 32'h0);
      check("reset_tx_data", 32'(tx_data_s), 32'h0);
      check("reset_rx_ack", 32'(rx_ack_s), 32'h0);
      sync_rstn = 1'b1;
      tick();

      for (int i = 0; i < 16; i++) begin
         bus_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
         if (vecs[i].rd) begin
            check($sformatf("vec%0d_rdata", i), bus_rdata_s, vecs[i].exp);
         end
      end

      // Release the transmitter: exactly 0x00..0x07 go out, 0x08 was dropped
      tx_hold = 1'b0;
      wait_sends(8, "fill_send_count");
      repeat (30) tick();
      check("fill_no_extra_send", 32'(sent_q.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < sent_q.size()) begin
            check($sformatf("fill_byte%0d", i), 32'(sent_q[i]), 32'(i));
         end
      end

      // Two-byte transmit with the ready model
      bus_op(1'b0, 1'b1, 1'b0, 32'h0000_0041);
      bus_op(1'b0, 1'b1, 1'b0, 32'h0000_0042);
      wait_sends(10, "tx2_send_count");
      repeat (30) tick();
      check("tx2_no_extra_send", 32'(sent_q.size()), 32'd10);
      if (sent_q.size() >= 10) begin
         check("tx2_byte0", 32'(sent_q[8]), 32'h41);
         check("tx2_byte1", 32'(sent_q[9]), 32'h42);
      end
      bus_op(1'b1, 1'b0, 1'b1, 32'h0);
      check("tx2_status_idle", bus_rdata_s, 32'h0000_0004);

      // Single received byte
      a0 = ack_cnt;
      rx_byte(8'h5A, "rx1_ack");
      tick();
      check("rx1_ack_count", 32'(ack_cnt - a0), 32'd1);
      bus_op(1'b1, 1'b0, 1'b1, 32'h0);
      check("rx1_status", bus_rdata_s, 32'h0000_0105);
      bus_op(1'b1, 1'b0, 1'b0, 32'h0);
      check("rx1_data", bus_rdata_s, 32'h0000_005A);
      bus_op(1'b1, 1'b0, 1'b1, 32'h0);
      check("rx1_status_empty", bus_rdata_s, 32'h0000_0004);

      // Fill RX FIFO, then overrun on a 9th byte
      for (int i = 0; i < 8; i++) begin
         rx_byte(8'(8'h10 + i), $sformatf("rxfill_ack%0d", i));
      end
      bus_op(1'b1, 1'b0, 1'b1, 32'h0);
      check("rxfull_status", bus_rdata_s, 32'h0000_0805);
      a0 = ack_cnt;
      rx_data_s  = 8'h99;
      rx_ready_s = 1'b1;
      repeat (4) tick();
      check("ovr_no_ack", 32'(ack_cnt - a0), 32'd0);
      bus_op(1'b1, 1'b0, 1'b1, 32'h0);
      check("ovr_status", bus_rdata_s, 32'h0000_080D);
      bus_op(1'b1, 1'b0, 1'b0, 32'h0);
      check("ovr_pop_data", bus_rdata_s, 32'h0000_0010);
      repeat (2) tick();
      check("ovr_late_ack", 32'(ack_cnt - a0), 32'd1);
      rx_ready_s = 1'b0;
      repeat (2) tick();
      bus_op(1'b0, 1'b1, 1'b1, 32'h0000_0008);
      bus_op(1'b1, 1'b0, 1'b1, 32'h0);
      check("ovr_cleared", bus_rdata_s, 32'h0000_0805);
      for (int i = 0; i < 8; i++) begin
         bus_op(1'b1, 1'b0, 1'b0, 32'h0);
         check($sformatf("drain%0d", i), bus_rdata_s, (i < 7) ? 32'(8'h11 + i) : 32'h0000_0099);
      end
      bus_op(1'b1, 1'b0, 1'b0, 32'h0);
      check("empty_data_read", bus_rdata_s, 32'h0);
      bus_op(1'b1, 1'b0, 1'b1, 32'h0);
      check("empty_rx_count", bus_rdata_s, 32'h0000_0004);

      // Reset while the transmitter is mid-handshake with 3 bytes queued
      tx_hold = 1'b1;
      repeat (2) tick();
      for (int i = 0; i < 4; i++) begin
         bus_op(1'b0, 1'b1, 1'b0, 32'(8'hA1 + i));
      end
      bus_op(1'b1, 1'b0, 1'b1, 32'h0);
      check("rst_pre_status", bus_rdata_s, 32'h0004_0000);
      tx_hold = 1'b0;
      wait_sends(11, "rst_first_send");
      if (sent_q.size() >= 11) begin
         check("rst_first_byte", 32'(sent_q[10]), 32'hA1);
      end
      tick();
      sync_rstn = 1'b0;
      #1;
      check("rst_async_rdata", bus_rdata_s, 32'h0);
      check("rst_async_tx_data", 32'(tx_data_s), 32'h0);
      check("rst_async_tx_send", 32'(tx_send_s), 32'h0);
      check("rst_async_rx_ack", 32'(rx_ack_s), 32'h0);
      repeat (3) tick();
      sync_rstn = 1'b1;
      tick();
      s0 = sent_q.size();
      bus_op(1'b1, 1'b0, 1'b1, 32'h0);
      check("rst_post_status", bus_rdata_s, 32'h0000_0004);
      repeat (40) tick();
      check("rst_no_send", 32'(sent_q.size()), 32'(s0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
